// File: rtl/rf_wb_arbiter_if.sv
// Writeback request and register-file write bus for rf_wb_arbiter.
// The slave modport is the arbiter. The master modport covers the requesters,
// the issue logic and the register file.
interface rf_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
);
    // Requester 0 (ALU)
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;

    // Requester 1 (LSU)
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;

    // Issue-side reservation
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;
    logic [NREGS-1:0]  busy;

    // Register file write port
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_address3;
    logic [DATA_W-1:0] rf_write_data;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  rsv_valid, rsv_addr,
        output req0_ready, req1_ready, busy,
        output rf_write_enable, rf_address3, rf_write_data
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output rsv_valid, rsv_addr,
        input  req0_ready, req1_ready, busy,
        input  rf_write_enable, rf_address3, rf_write_data
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter that shares the single register-file write port between
// the ALU (requester 0) and the LSU (requester 1). The winning request is
// registered into a one-stage write pipeline. A busy scoreboard tracks the
// destination registers that have a write pending.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_wb_arbiter_if.slave       bus
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    // Arbitration
    logic              w_grant0;
    logic              w_grant1;
    logic              w_any_grant;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;

    // Last granted requester: 0 = ALU, 1 = LSU
    logic              r_last_grant;

    // Write stage
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // Scoreboard
    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_next;

    // Grant selection. A single valid requester always wins. On a tie, the
    // requester that did not win last time wins. Nothing is granted in reset.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (rst) begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end else if (bus.req0_valid && bus.req1_valid) begin
            if (r_last_grant) begin
                w_grant0 = 1'b1;
            end else begin
                w_grant1 = 1'b1;
            end
        end else if (bus.req0_valid) begin
            w_grant0 = 1'b1;
        end else if (bus.req1_valid) begin
            w_grant1 = 1'b1;
        end else begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end
    end

    assign w_any_grant = w_grant0 | w_grant1;

    // Select the address and data of the winner for the write stage
    always_comb begin
        w_win_addr = bus.req0_addr;
        w_win_data = bus.req0_data;
        if (w_grant1) begin
            w_win_addr = bus.req1_addr;
            w_win_data = bus.req1_data;
        end else begin
            w_win_addr = bus.req0_addr;
            w_win_data = bus.req0_data;
        end
    end

    // Next scoreboard value. Clear on commit first, then apply a reservation,
    // so a reservation on the same edge as the commit supersedes the clear.
    // x0 never becomes busy.
    always_comb begin
        w_busy_next = r_busy;
        if (r_we) begin
            w_busy_next[r_addr] = 1'b0;
        end else begin
            w_busy_next = r_busy;
        end
        if (bus.rsv_valid && (bus.rsv_addr != ADDR_ZERO)) begin
            w_busy_next[bus.rsv_addr] = 1'b1;
        end else begin
            w_busy_next[0] = 1'b0;
        end
        w_busy_next[0] = 1'b0;
    end

    // Write stage and round-robin pointer. A granted x0 write is still
    // accepted, but its write enable is suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_addr       <= ADDR_ZERO;
            r_data       <= {DATA_W{1'b0}};
            r_last_grant <= 1'b1;
        end else if (w_any_grant) begin
            r_we         <= (w_win_addr != ADDR_ZERO);
            r_addr       <= w_win_addr;
            r_data       <= w_win_data;
            r_last_grant <= w_grant1;
        end else begin
            r_we         <= 1'b0;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= {NREGS{1'b0}};
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign bus.req0_ready      = w_grant0;
    assign bus.req1_ready      = w_grant1;
    assign bus.busy            = r_busy;
    assign bus.rf_write_enable = r_we;
    assign bus.rf_address3     = r_addr;
    assign bus.rf_write_data   = r_data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter. It runs directed scenarios and then
// randomized traffic. Expected values come from a transaction-level model
// that works on integers and a bit array.
module tb_rf_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) bus ();

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_last;
    bit [31:0]   m_busy;
    bit          m_we;
    int          m_addr;
    bit [31:0]   m_data;
    int          g_last;     // grant the model expected on the last step (-1 = none)
    logic        obs_r0, obs_r1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner this cycle, from the arbitration rules
    function automatic int predict();
        if (rst) return -1;
        if (bus.req0_valid && bus.req1_valid) return 1 - m_last;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    // One clock: check ready before the edge, advance the model, check outputs after
    task automatic step();
        int g;
        bit [31:0] nb;
        #2;
        g = predict();
        obs_r0 = bus.req0_ready;
        obs_r1 = bus.req1_ready;
        chk("req0_ready", {63'd0, bus.req0_ready}, {63'd0, (g == 0)});
        chk("req1_ready", {63'd0, bus.req1_ready}, {63'd0, (g == 1)});
        @(posedge clk);
        if (rst) begin
            m_last = 1; m_busy = 32'd0; m_we = 1'b0; m_addr = 0; m_data = 32'd0;
        end else begin
            nb = m_busy;
            if (m_we) nb[m_addr] = 1'b0;
            if (bus.rsv_valid && bus.rsv_addr != 5'd0) nb[bus.rsv_addr] = 1'b1;
            m_busy = nb;
            if (g >= 0) begin
                m_addr = (g == 0) ? int'(bus.req0_addr) : int'(bus.req1_addr);
                m_data = (g == 0) ? bus.req0_data : bus.req1_data;
                m_we   = (m_addr != 0);
                m_last = g;
            end else begin
                m_we = 1'b0;
            end
        end
        g_last = g;
        #1;
        chk("rf_write_enable", {63'd0, bus.rf_write_enable}, {63'd0, m_we});
        chk("rf_address3", {59'd0, bus.rf_address3}, 64'(m_addr));
        chk("rf_write_data", {32'd0, bus.rf_write_data}, {32'd0, m_data});
        chk("busy", {32'd0, bus.busy}, {32'd0, m_busy});
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = 5'd0; bus.req0_data = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_addr = 5'd0; bus.req1_data = 32'd0;
        bus.rsv_valid  = 1'b0; bus.rsv_addr  = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        m_last = 1; m_busy = 32'd0; m_we = 1'b0; m_addr = 0; m_data = 32'd0;
        rst = 1'b1;
        step(); step();
        chk("reset_we", {63'd0, bus.rf_write_enable}, 64'd0);
        chk("reset_busy", {32'd0, bus.busy}, 64'd0);
        rst = 1'b0;

        // 1: single ALU write
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'hDEADBEEF;
        step();
        chk("t1_ready", {63'd0, obs_r0}, 64'd1);
        chk("t1_we", {63'd0, bus.rf_write_enable}, 64'd1);
        chk("t1_addr", {59'd0, bus.rf_address3}, 64'd5);
        chk("t1_data", {32'd0, bus.rf_write_data}, 64'hDEADBEEF);
        idle_inputs(); step();
        chk("t1_we_off", {63'd0, bus.rf_write_enable}, 64'd0);

        // 2: continuous tie alternates, starting with the ALU
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h11;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_grant_alu", {63'd0, obs_r0}, {63'd0, (i % 2 == 0)});
            chk("t2_addr", {59'd0, bus.rf_address3}, (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("t2_we", {63'd0, bus.rf_write_enable}, 64'd1);
        end
        idle_inputs(); step();

        // 3: reserve 7, LSU writes it three cycles later
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7;
        step();
        idle_inputs();
        chk("t3_busy_set", {63'd0, bus.busy[7]}, 64'd1);
        step(); step();
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'hCAFE0007;
        step();
        idle_inputs();
        chk("t3_we", {63'd0, bus.rf_write_enable}, 64'd1);
        chk("t3_busy_pending", {63'd0, bus.busy[7]}, 64'd1);
        step();
        chk("t3_busy_clear", {63'd0, bus.busy[7]}, 64'd0);

        // 4: set wins over clear; reserving x0 does nothing
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = 32'h99;
        step();
        idle_inputs();
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
        step();
        idle_inputs();
        chk("t4_set_wins", {63'd0, bus.busy[9]}, 64'd1);
        do_reset();
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd0;
        step();
        idle_inputs();
        chk("t4_x0_rsv", {32'd0, bus.busy}, 64'd0);

        // 5: x0 write accepted and dropped
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd0; bus.req0_data = 32'h1234;
        step();
        idle_inputs();
        chk("t5_ready", {63'd0, obs_r0}, 64'd1);
        chk("t5_we", {63'd0, bus.rf_write_enable}, 64'd0);

        // 6: reset while an LSU write is in flight
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd3;
        step();
        idle_inputs();
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd3; bus.req1_data = 32'h33;
        step();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd4;
        rst = 1'b1;
        step();
        chk("t6_ready_in_rst", {63'd0, obs_r0}, 64'd0);
        chk("t6_we", {63'd0, bus.rf_write_enable}, 64'd0);
        chk("t6_busy", {32'd0, bus.busy}, 64'd0);
        rst = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd6;
        step();
        chk("t6_first_tie_alu", {63'd0, obs_r0}, 64'd1);
        idle_inputs(); step();

        // Random traffic. A requester holds its request until it is accepted.
        for (int c = 0; c < 3000; c++) begin
            if (!bus.req0_valid || g_last == 0) begin
                bus.req0_valid = ($urandom_range(0, 99) < 60);
                bus.req0_addr  = 5'($urandom_range(0, 31));
                bus.req0_data  = $urandom;
            end
            if (!bus.req1_valid || g_last == 1) begin
                bus.req1_valid = ($urandom_range(0, 99) < 50);
                bus.req1_addr  = 5'($urandom_range(0, 31));
                bus.req1_data  = $urandom;
            end
            bus.rsv_valid = ($urandom_range(0, 99) < 40);
            bus.rsv_addr  = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 99) < 2);
            step();
        end
        rst = 1'b0;
        idle_inputs(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: requester 0 (ALU) and requester 1 (load/store unit).
- Round-robin arbitration; the winner is registered into a one-stage write pipeline that drives the register file write port.
- Keeps a busy scoreboard: destination registers are reserved at issue and released when the write commits.
- Issue logic uses `busy` for RAW-hazard stalls.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register address width.
- NREGS, 32, number of architectural registers (= 2^ADDR_W).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0_valid  in  1  ALU writeback request.
- req0_ready  out  1  ALU request accepted this cycle.
- req0_addr  in  ADDR_W  ALU destination register.
- req0_data  in  DATA_W  ALU result.
- req1_valid  in  1  LSU writeback request.
- req1_ready  out  1  LSU request accepted this cycle.
- req1_addr  in  ADDR_W  LSU destination register.
- req1_data  in  DATA_W  LSU load data.
- rsv_valid  in  1  issue reserves a destination register.
- rsv_addr  in  ADDR_W  register to reserve.
- busy  out  NREGS  bit i = 1: register i has a pending write.
- rf_write_enable  out  1  to register file write enable.
- rf_address3  out  ADDR_W  to register file write address.
- rf_write_data  out  DATA_W  to register file write data.

Behaviour:
Handshake:
- A transfer occurs when valid && ready in the same cycle.
- Requester holds addr and data stable while valid is high and ready is low.
- ready is combinational from both valids and the last_grant flop.
- The register file never back-pressures, so exactly one request is granted whenever at least one is valid.

Arbitration:
- Only one valid: that requester is granted.
- Both valid: grant the requester not in last_grant.
- last_grant updates only on a grant (value 0 = ALU, 1 = LSU); reset value 1, so ALU wins the first tie.
- Idle cycles do not change last_grant.

Write stage:
- Granted addr and data are registered; rf_write_enable is high the cycle after acceptance (latency 1).
- rf_write_enable is 0 when no grant occurred, or when the granted addr is 0. An x0 write is still accepted (ready = 1) but dropped.
- Back-to-back grants give a write every cycle, with no bubbles.

Scoreboard:
- On an edge with rsv_valid && rsv_addr != 0: busy[rsv_addr] <= 1.
- On an edge with rf_write_enable: busy[rf_address3] <= 0 (commit edge). The register file holds the new value after this same edge.
- Set and clear of the same address on the same edge: set wins, since a newer reservation supersedes.
- busy[0] is constant 0.
- A write to a non-busy register is legal and leaves busy unchanged.

Reset (rst = 1 at an edge), including mid-operation:
- Registered outputs clear: rf_write_enable = 0, rf_address3 = 0, rf_write_data = 0, busy = 0, last_grant = 1.
- req0_ready and req1_ready are forced 0 while rst is high. A request presented during reset is not accepted.
- An in-flight write-stage entry is discarded.

Test Plan:
1. Only req0_valid, addr = 5, data = 0xDEADBEEF, at cycle N:
   - req0_ready = 1 at N.
   - rf_write_enable = 1, rf_address3 = 5, rf_write_data = 0xDEADBEEF at N+1.
   - rf_write_enable = 0 at N+2.
2. Both valid continuously for 4 cycles (addrs 1/2, data 0x11/0x22) after reset:
   - Grants ALU, LSU, ALU, LSU.
   - rf_address3 sequence 1, 2, 1, 2, starting one cycle later.
3. rsv_valid, addr = 7 at cycle N:
   - busy[7] = 1 from N+1.
   - req1 writes 7 at N+3: rf_write_enable at N+4; busy[7] = 0 from N+5.
4. Set/clear collision:
   - Write to 9 commits on the same edge as rsv_valid, addr = 9 → busy[9] stays 1.
   - rsv_valid, addr = 0 → busy stays all-zero.
5. req0_valid, addr = 0, data = 0x1234 → req0_ready = 1, rf_write_enable stays 0 next cycle.
6. rst asserted the cycle after acceptance of req1 (addr = 3) with busy[3] = 1:
   - rf_write_enable = 0 and busy = 0 after the reset edge.
   - First tie after reset grants ALU.
